// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b1;
    localparam logic PARITY_ODD  = 1'b0;

    typedef struct packed {
        logic brk;
        logic frm;
        logic par;
    } rx_status_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received words plus status.
// Push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; empty gates the head output instead.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample voting, per-word status and valid/ready output.
// Optional output FIFO selected by UART_RX_FIFO_EN; otherwise a single holding register.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    input  logic                 parity_enable,
    input  logic                 parity_mode,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    input  logic                 err_clr
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE/2);
    localparam logic [SW-1:0] S_DEC = SW'(OVERSAMPLE/2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_DLAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] N_SLAST = NW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_rx_os: FIFO_DEPTH must be a power of 2 >= 2");
    end

    logic rx_m, rx_s;

    rx_state_t            state, state_nx;
    logic [SW-1:0]        s_q, s_nx;
    logic [NW-1:0]        n_q, n_nx;
    logic [1:0]           v_q, v_nx;
    logic [DATA_BITS-1:0] sh_q, sh_nx;
    logic                 pbit_q, pbit_nx;
    logic                 pen_q, pen_nx;
    logic                 pmode_q, pmode_nx;
    logic                 par_q, par_nx;
    logic                 frm_q, frm_nx;
    logic                 armed_q, armed_nx;

    logic                 vote, dec, bit_end, frm_fin;
    logic                 push;
    rx_status_t           push_st;
    logic                 ovr_set;
    rx_status_t           out_st;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            v_q     <= 2'b11;
            sh_q    <= '0;
            pbit_q  <= 1'b0;
            pen_q   <= 1'b0;
            pmode_q <= 1'b0;
            par_q   <= 1'b0;
            frm_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state   <= state_nx;
            s_q     <= s_nx;
            n_q     <= n_nx;
            v_q     <= v_nx;
            sh_q    <= sh_nx;
            pbit_q  <= pbit_nx;
            pen_q   <= pen_nx;
            pmode_q <= pmode_nx;
            par_q   <= par_nx;
            frm_q   <= frm_nx;
            armed_q <= armed_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_nx     = s_q;
        n_nx     = n_q;
        v_nx     = v_q;
        sh_nx    = sh_q;
        pbit_nx  = pbit_q;
        pen_nx   = pen_q;
        pmode_nx = pmode_q;
        par_nx   = par_q;
        frm_nx   = frm_q;
        armed_nx = armed_q;
        push     = 1'b0;
        push_st  = '0;

        vote    = maj3(v_q[0], v_q[1], rx_s);
        dec     = sample_tick && (s_q == S_DEC);
        bit_end = sample_tick && (s_q == S_END);
        frm_fin = frm_q | ~vote;

        if (sample_tick && state != IDLE) begin
            s_nx = (s_q == S_END) ? '0 : s_q + 1'b1;
            if (s_q == S_V0) v_nx[0] = rx_s;
            if (s_q == S_V1) v_nx[1] = rx_s;
        end

        case (state)
            IDLE: begin
                if (rx_s) armed_nx = 1'b1;
                if (sample_tick && armed_q && !rx_s) begin
                    state_nx = START;
                    s_nx     = '0;
                    n_nx     = '0;
                    pen_nx   = parity_enable;
                    pmode_nx = parity_mode;
                    par_nx   = 1'b0;
                    frm_nx   = 1'b0;
                    pbit_nx  = 1'b0;
                end
            end
            START: begin
                if (dec && vote) begin
                    state_nx = IDLE;
                end else if (bit_end) begin
                    state_nx = DATA;
                    n_nx     = '0;
                end
            end
            DATA: begin
                if (dec) sh_nx = {vote, sh_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (n_q == N_DLAST) begin
                        state_nx = pen_q ? PARITY : STOP;
                        n_nx     = '0;
                    end else begin
                        n_nx = n_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (dec) begin
                    pbit_nx = vote;
                    par_nx  = (pmode_q == PARITY_EVEN) ? ^{sh_q, vote} : ~^{sh_q, vote};
                end
                if (bit_end) state_nx = STOP;
            end
            STOP: begin
                if (dec) begin
                    frm_nx = frm_fin;
                    if (n_q == N_SLAST) begin
                        // Last stop bit: push at mid-bit so the next start edge is never missed.
                        push        = 1'b1;
                        push_st.par = par_q;
                        push_st.frm = frm_fin;
                        push_st.brk = (sh_q == '0) && !(pen_q && pbit_q) && frm_fin;
                        state_nx    = IDLE;
                        s_nx        = '0;
                        if (push_st.brk) armed_nx = 1'b0;
                    end
                end
                if (bit_end && n_q != N_SLAST) n_nx = n_q + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef UART_RX_FIFO_EN
    localparam int FW = DATA_BITS + 3;

    logic [FW-1:0] head;
    logic          fifo_full, fifo_empty, fifo_pop;

    assign fifo_pop = !fifo_empty && rx_ready;

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_st, sh_q}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ovr_set  = push && fifo_full && !fifo_pop;
    assign rx_valid = !fifo_empty;
    assign rx_data  = head[DATA_BITS-1:0];
    assign out_st   = rx_status_t'(head[FW-1 -: 3]);
`else
    logic                 hold_vld;
    logic [DATA_BITS-1:0] hold_dat;
    rx_status_t           hold_st;
    logic                 hold_pop;

    assign hold_pop = hold_vld && rx_ready;
    assign ovr_set  = push && hold_vld && !rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
            hold_st  <= '0;
        end else if (push && (!hold_vld || hold_pop)) begin
            hold_vld <= 1'b1;
            hold_dat <= sh_q;
            hold_st  <= push_st;
        end else if (hold_pop) begin
            hold_vld <= 1'b0;
        end
    end

    assign rx_valid = hold_vld;
    assign rx_data  = hold_dat;
    assign out_st   = hold_st;
`endif

    assign parity_err = out_st.par;
    assign frame_err  = out_st.frm;
    assign break_det  = out_st.brk;

    // A new overrun beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)          overrun_err <= 1'b0;
        else if (ovr_set) overrun_err <= 1'b1;
        else if (err_clr) overrun_err <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8-bit frames at 16x oversampling, tick every other clock.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_tick;
    logic       rx;
    logic       parity_enable;
    logic       parity_mode;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       overrun_err;
    logic       err_clr;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [7:0] last_data;
    logic       last_par, last_frm, last_brk;

    uart_rx_os #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_tick   (sample_tick),
        .rx            (rx),
        .parity_enable (parity_enable),
        .parity_mode   (parity_mode),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .break_det     (break_det),
        .overrun_err   (overrun_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            sample_tick = ~sample_tick;
        end
    end

    // Record every accepted word (handshake completes at the following posedge).
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            pops++;
            last_data = rx_data;
            last_par  = parity_err;
            last_frm  = frame_err;
            last_brk  = break_det;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pb,
                              input bit stopv, input int gbit);
        rx = 1'b0;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                rx = d[i];  ticks(8);
                rx = ~d[i]; ticks(1);
                rx = d[i];  ticks(7);
            end else begin
                rx = d[i];
                ticks(16);
            end
        end
        if (pen) begin
            rx = pb;
            ticks(16);
        end
        rx = stopv;
        ticks(16);
        rx = 1'b1;
        ticks(16);
    endtask

    int p0;

    initial begin
        rst = 1'b1; rx = 1'b1; parity_enable = 1'b0; parity_mode = 1'b0;
        rx_ready = 1'b1; err_clr = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 0);
        chk("reset_overrun", overrun_err, 0);
        chk("reset_status", {parity_err, frame_err, break_det}, 0);
        ticks(32);

        // 8N1 0xA5
        p0 = pops;
        send_frame(8'hA5, 0, 0, 1, -1);
        chk("a5_pops", pops - p0, 1);
        chk("a5_data", last_data, 8'hA5);
        chk("a5_status", {last_par, last_frm, last_brk}, 0);

        // 8E1 0x3C, wrong then right parity; then odd mode
        parity_enable = 1'b1; parity_mode = 1'b1;
        send_frame(8'h3C, 1, 1, 1, -1);
        chk("even_bad_data", last_data, 8'h3C);
        chk("even_bad_par", last_par, 1);
        send_frame(8'h3C, 1, 0, 1, -1);
        chk("even_ok_par", last_par, 0);
        parity_mode = 1'b0;
        send_frame(8'h3C, 1, 1, 1, -1);
        chk("odd_ok_par", last_par, 0);
        chk("parity_pops", pops - p0, 4);
        parity_enable = 1'b0;

        // 5-tick low glitch on idle line
        p0 = pops;
        rx = 1'b0; ticks(5);
        rx = 1'b1; ticks(32);
        chk("false_start_pops", pops - p0, 0);

        // Single-tick inversion at s=8 of data bit 3
        send_frame(8'h00, 0, 0, 1, 3);
        chk("glitch_pops", pops - p0, 1);
        chk("glitch_data", last_data, 8'h00);
        chk("glitch_status", {last_par, last_frm, last_brk}, 0);

        // Stop bit sampled low
        send_frame(8'h55, 0, 0, 0, -1);
        chk("frm_data", last_data, 8'h55);
        chk("frm_err", last_frm, 1);
        chk("frm_brk", last_brk, 0);

        // Break: 12 bit times low
        p0 = pops;
        rx = 1'b0; ticks(192);
        chk("break_pops", pops - p0, 1);
        rx = 1'b1; ticks(32);
        chk("break_pops_after", pops - p0, 1);
        chk("break_data", last_data, 8'h00);
        chk("break_frm", last_frm, 1);
        chk("break_det", last_brk, 1);
        send_frame(8'h81, 0, 0, 1, -1);
        chk("post_break_pops", pops - p0, 2);
        chk("post_break_data", last_data, 8'h81);
        chk("post_break_status", {last_par, last_frm, last_brk}, 0);

        // Overrun with consumer stalled
        rx_ready = 1'b0;
`ifdef UART_RX_FIFO_EN
        for (int w = 1; w <= 5; w++) send_frame(8'(w * 8'h11), 0, 0, 1, -1);
        chk("fifo_overrun", overrun_err, 1);
        for (int w = 1; w <= 4; w++) begin
            chk("fifo_valid", rx_valid, 1);
            chk("fifo_head", rx_data, 8'(w * 8'h11));
            rx_ready = 1'b1;
            @(posedge clk); #1;
            rx_ready = 1'b0;
        end
        chk("fifo_drained", rx_valid, 0);
`else
        send_frame(8'h11, 0, 0, 1, -1);
        chk("ovr_none_yet", overrun_err, 0);
        send_frame(8'h22, 0, 0, 1, -1);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_flag", overrun_err, 1);
        p0 = pops;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        chk("ovr_pop_data", last_data, 8'h11);
        chk("ovr_pop_count", pops - p0, 1);
        chk("ovr_drained", rx_valid, 0);
`endif
        chk("ovr_sticky", overrun_err, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("ovr_cleared", overrun_err, 0);

        // Reset in the middle of a data bit with a word held
        send_frame(8'h66, 0, 0, 1, -1);
        chk("pre_rst_valid", rx_valid, 1);
        chk("pre_rst_data", rx_data, 8'h66);
        rx = 1'b0; ticks(16);
        rx = 1'b1; ticks(16);
        rx = 1'b0; ticks(16);
        rx = 1'b1; ticks(8);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_status", {parity_err, frame_err, break_det}, 0);
        chk("rst_overrun", overrun_err, 0);
        ticks(32);
        rx_ready = 1'b1;
        p0 = pops;
        send_frame(8'hF0, 0, 0, 1, -1);
        chk("post_rst_pops", pops - p0, 1);
        chk("post_rst_data", last_data, 8'hF0);
        chk("post_rst_status", {last_par, last_frm, last_brk}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
